// File: rtl/bitop_accumulator.sv
// Streaming bitwise fold unit: folds a valid/ready burst with AND/OR/XOR/XNOR.
// Optional BITACC_OVF_EN adds out_ovf, flagging bursts longer than the counter.
module bitop_accumulator #(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_op,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_and_red,
  output logic               out_or_red,
  output logic               out_xor_red
`ifdef BITACC_OVF_EN
  ,
  output logic               out_ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [WIDTH-1:0]   acc;
  logic [1:0]         op;
  logic [COUNT_W-1:0] count;
  logic               beat;

  function automatic logic [WIDTH-1:0] fold(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [1:0]       o
  );
    logic [WIDTH-1:0] r;
    r = a & b;
    unique case (o)
      2'b00: r = a & b;
      2'b01: r = a | b;
      2'b10: r = a ^ b;
      2'b11: r = ~(a ^ b);
    endcase
    return r;
  endfunction

  assign in_ready = (state != HOLD) && !reset;
  assign beat     = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (beat) state_n = in_last ? HOLD : ACCUM;
      ACCUM:   if (beat && in_last) state_n = HOLD;
      HOLD:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The op is latched on the first beat; later beats' in_op is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      op    <= '0;
      count <= '0;
    end else if (beat) begin
      if (state == IDLE) begin
        acc   <= in_data;
        op    <= in_op;
        count <= {{(COUNT_W-1){1'b0}}, 1'b1};
      end else begin
        acc <= fold(acc, in_data, op);
        if (count != '1) count <= count + 1'b1;
      end
    end
  end

`ifdef BITACC_OVF_EN
  logic ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (beat) begin
      if (state == IDLE)   ovf <= 1'b0;
      else if (&count)     ovf <= 1'b1;
    end
  end

  assign out_ovf = ovf;
`endif

  assign out_valid   = (state == HOLD) && !reset;
  assign out_data    = acc;
  assign out_count   = count;
  assign out_and_red = &acc;
  assign out_or_red  = |acc;
  assign out_xor_red = ^acc;

endmodule
